// File: rtl/spi_pkg.sv
// Shared constants and engine state type for the FIFO-backed SPI master.
// Register map indices and CTRL/STATUS bit positions live here.
package spi_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_SS     = 3'd2;
  localparam logic [2:0] ADDR_DATA   = 3'd3;
  localparam logic [2:0] ADDR_DIV    = 3'd4;

  localparam int CTRL_CPOL   = 0;
  localparam int CTRL_CPHA   = 1;
  localparam int CTRL_LSB    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_RX_EMPTY = 4;
  localparam int ST_OVERRUN  = 5;

  typedef enum logic [1:0] {
    IDLE,
    FIRST_HALF,
    SECOND_HALF,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_fifo.sv
// Count-based synchronous FIFO with combinational head.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module spi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_rdat  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_wdat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_fifo.sv
// Bus-attached SPI master: four modes, MSB/LSB first, run-time divider,
// slave selects and TX/RX byte FIFOs for back-to-back transfers.
module spi_master_fifo
  import spi_pkg::*;
#(
  parameter int NSS        = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DIVW       = 8,
  parameter int DIV_RESET  = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [2:0]     i_addr,
  input  logic           i_cs,
  input  logic           i_we,
  input  logic [7:0]     i_dat,
  output logic [7:0]     o_dat,
  output logic           o_irq,
  input  logic           i_miso,
  output logic           o_mosi,
  output logic           o_sck,
  output logic [NSS-1:0] o_ss
);

  logic [3:0]      ctrl_q;
  logic [NSS-1:0]  ss_q;
  logic [DIVW-1:0] div_q;
  logic            ovr_q;

  spi_state_e      state_q;
  spi_state_e      state_d;
  logic [DIVW-1:0] cnt_q;
  logic [DIVW-1:0] div_s_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q;
  logic [7:0]      sh_nxt;
  logic            miso_q;
  logic            cpol_q;
  logic            cpha_q;
  logic            lsb_q;
  logic            half_end;
  logic            load;

  logic            wr_en;
  logic            tx_push;
  logic            tx_pop;
  logic [7:0]      tx_head;
  logic            tx_full;
  logic            tx_empty;
  logic            rx_push;
  logic            rx_pop;
  logic [7:0]      rx_head;
  logic            rx_full;
  logic            rx_empty;
  logic            rx_drop;
  logic            busy;
  logic            out_bit;

  assign wr_en   = i_cs & i_we;
  assign tx_push = wr_en & (i_addr == ADDR_DATA);
  assign rx_pop  = i_cs & ~i_we & (i_addr == ADDR_DATA);
  // A full RX still takes the byte if software pops it this cycle.
  assign rx_drop = rx_push & rx_full & ~rx_pop;

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (tx_push),
    .i_wdat  (i_dat),
    .i_pop   (tx_pop),
    .o_rdat  (tx_head),
    .o_full  (tx_full),
    .o_empty (tx_empty)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (rx_push),
    .i_wdat  (sh_nxt),
    .i_pop   (rx_pop),
    .o_rdat  (rx_head),
    .o_full  (rx_full),
    .o_empty (rx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ctrl_q <= '0;
      ss_q   <= '0;
      div_q  <= DIVW'(DIV_RESET);
      ovr_q  <= 1'b0;
    end else begin
      if (wr_en && i_addr == ADDR_CTRL) ctrl_q <= i_dat[3:0];
      if (wr_en && i_addr == ADDR_SS)   ss_q   <= i_dat[NSS-1:0];
      if (wr_en && i_addr == ADDR_DIV)  div_q  <= i_dat[DIVW-1:0];
      if (rx_drop)
        ovr_q <= 1'b1;
      else if (wr_en && i_addr == ADDR_STATUS)
        ovr_q <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE) | ~tx_empty;

  always_comb begin
    o_dat = '0;
    unique case (i_addr)
      ADDR_CTRL:   o_dat[3:0] = ctrl_q;
      ADDR_STATUS: o_dat[5:0] = {ovr_q, rx_empty, rx_full,
                                 tx_empty, tx_full, busy};
      ADDR_SS:     o_dat[NSS-1:0] = ss_q;
      ADDR_DATA:   o_dat = rx_empty ? 8'h00 : rx_head;
      ADDR_DIV:    o_dat[DIVW-1:0] = div_q;
      default:     o_dat = '0;
    endcase
  end

  assign half_end = (cnt_q == div_s_q);
  // Shift in the bit sampled at the end of the first half.
  assign sh_nxt   = lsb_q ? {miso_q, sh_q[7:1]} : {sh_q[6:0], miso_q};
  assign out_bit  = lsb_q ? sh_q[0] : sh_q[7];

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          load    = 1'b1;
          state_d = FIRST_HALF;
        end
      end
      FIRST_HALF: begin
        if (half_end) state_d = SECOND_HALF;
      end
      SECOND_HALF: begin
        if (half_end)
          state_d = (bit_q == 3'd7) ? DONE : FIRST_HALF;
      end
      DONE: begin
        rx_push = 1'b1;
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          load    = 1'b1;
          state_d = FIRST_HALF;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_s_q <= DIVW'(DIV_RESET);
      bit_q   <= '0;
      sh_q    <= '0;
      miso_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sh_q    <= tx_head;
        cpol_q  <= ctrl_q[CTRL_CPOL];
        cpha_q  <= ctrl_q[CTRL_CPHA];
        lsb_q   <= ctrl_q[CTRL_LSB];
        div_s_q <= div_q;
        cnt_q   <= '0;
        bit_q   <= '0;
      end else if (state_q == FIRST_HALF || state_q == SECOND_HALF) begin
        if (half_end) begin
          cnt_q <= '0;
          if (state_q == FIRST_HALF) begin
            miso_q <= i_miso;
          end else if (bit_q != 3'd7) begin
            bit_q <= bit_q + 1'b1;
            sh_q  <= sh_nxt;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_sck = cpol_q;
    unique case (state_q)
      IDLE:        o_sck = ctrl_q[CTRL_CPOL];
      FIRST_HALF:  o_sck = cpol_q ^ cpha_q;
      SECOND_HALF: o_sck = cpol_q ^ ~cpha_q;
      DONE:        o_sck = cpol_q;
      default:     o_sck = cpol_q;
    endcase
  end

  assign o_mosi = (state_q != IDLE) && (|ss_q) ? out_bit : 1'b0;
  assign o_ss   = ss_q;
  assign o_irq  = ctrl_q[CTRL_IRQ_EN] &
                  (~rx_empty | (tx_empty & ~busy));

endmodule

// File: tb/tb_spi_master_fifo.sv
// Scoreboard bench for spi_master_fifo: expectations are queued by the
// stimulus thread and consumed by a negedge monitor.
module tb_spi_master_fifo;

  localparam int K_RD   = 0;
  localparam int K_SCK  = 1;
  localparam int K_MOSI = 2;
  localparam int K_EQ   = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  typedef struct {
    int   cyc;
    logic b;
  } edge_t;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [2:0] i_addr;
  logic       i_cs;
  logic       i_we;
  logic [7:0] i_dat;
  logic [7:0] o_dat;
  logic       o_irq;
  logic       i_miso;
  logic       o_mosi;
  logic       o_sck;
  logic [3:0] o_ss;

  exp_t  q[$];
  edge_t eq[$];
  exp_t  x;
  edge_t ev;
  int    checks = 0;
  int    errors = 0;
  int    cyc_n  = 0;
  int    k      = 0;
  int    p;
  logic  sck_prev = 1'b0;
  logic  edge_chk = 1'b0;
  logic  loopback = 1'b0;
  logic [7:0] pat = 8'h3C;
  logic [7:0] byt;

  spi_master_fifo #(
    .NSS(4), .FIFO_DEPTH(4), .DIVW(8), .DIV_RESET(1)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_addr  (i_addr),
    .i_cs    (i_cs),
    .i_we    (i_we),
    .i_dat   (i_dat),
    .o_dat   (o_dat),
    .o_irq   (o_irq),
    .i_miso  (i_miso),
    .o_mosi  (o_mosi),
    .o_sck   (o_sck),
    .o_ss    (o_ss)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc_n <= cyc_n + 1;

  always @(posedge o_sck) k = k + 1;

  assign i_miso = loopback ? o_mosi : pat[k[2:0]];

  task automatic check(string n, logic [31:0] act, logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", n, act, exv);
    end
  endtask

  always @(negedge i_clk) begin
    if (edge_chk && o_sck && !sck_prev) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sck_rise: got rise at cycle %0d, want none",
                 cyc_n);
      end else begin
        ev = eq.pop_front();
        check("sck_rise_cycle", cyc_n, ev.cyc);
        check("mosi_at_rise", {31'd0, o_mosi}, {31'd0, ev.b});
      end
    end
    sck_prev = o_sck;
    while (q.size() > 0 && q[0].kind != K_RD) begin
      x = q.pop_front();
      case (x.kind)
        K_SCK:   check(x.name, {31'd0, o_sck}, {24'd0, x.val});
        K_MOSI:  check(x.name, {31'd0, o_mosi}, {24'd0, x.val});
        default: check(x.name, eq.size(), 0);
      endcase
    end
    if (i_cs && !i_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got read of addr %0d, want none",
                 i_addr);
      end else begin
        x = q.pop_front();
        check(x.name, {24'd0, o_dat}, {24'd0, x.val});
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_dat = d;
    tick();
    i_cs = 1'b0; i_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e,
                    input string n);
    q.push_back('{K_RD, e, n});
    i_cs = 1'b1; i_we = 1'b0; i_addr = a;
    tick();
    i_cs = 1'b0;
  endtask

  task automatic pin(input int kd, input logic [7:0] e, input string n);
    q.push_back('{kd, e, n});
  endtask

  task automatic waitc(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_addr = '0; i_cs = 1'b0; i_we = 1'b0; i_dat = '0;
    waitc(3);
    i_reset = 1'b0;
    tick();

    // Reset state
    pin(K_SCK, 8'd0, "rst_sck");
    pin(K_MOSI, 8'd0, "rst_mosi");
    tick();
    rd(3'd0, 8'h00, "rst_ctrl");
    rd(3'd1, 8'h14, "rst_status");
    rd(3'd2, 8'h00, "rst_ss");
    rd(3'd4, 8'h01, "rst_div");
    rd(3'd5, 8'h00, "rst_addr5");
    rd(3'd3, 8'h00, "rst_data_empty");

    // Mode 0, DIV=1, loopback
    wr(3'd2, 8'h01);
    loopback = 1'b1;
    edge_chk = 1'b1;
    byt = 8'hA5;
    wr(3'd3, byt);
    p = cyc_n;
    for (int i = 0; i < 8; i++) eq.push_back('{p + 3 + 4*i, byt[7-i]});
    while (cyc_n < p + 33) tick();
    rd(3'd1, 8'h15, "m0_busy_last");
    rd(3'd1, 8'h04, "m0_busy_fell");
    rd(3'd3, 8'hA5, "m0_rx");
    pin(K_EQ, 8'd0, "m0_edges_left");
    tick();
    edge_chk = 1'b0;

    // Mode 3, LSB first, patterned MISO
    loopback = 1'b0;
    wr(3'd0, 8'h07);
    k = 0;
    pin(K_SCK, 8'd1, "m3_sck_idle");
    tick();
    wr(3'd3, 8'h00);
    waitc(40);
    rd(3'd3, 8'h3C, "m3_rx");
    wr(3'd0, 8'h00);

    // Back-to-back, DIV=0
    wr(3'd4, 8'h00);
    loopback = 1'b1;
    edge_chk = 1'b1;
    wr(3'd3, 8'h01);
    p = cyc_n;
    for (int b = 0; b < 4; b++) begin
      byt = 8'(b + 1);
      for (int i = 0; i < 8; i++)
        eq.push_back('{p + 2 + 2*i + 17*b, byt[7-i]});
    end
    wr(3'd3, 8'h02);
    wr(3'd3, 8'h03);
    wr(3'd3, 8'h04);
    waitc(78);
    rd(3'd3, 8'h01, "b2b_rx0");
    rd(3'd3, 8'h02, "b2b_rx1");
    rd(3'd3, 8'h03, "b2b_rx2");
    rd(3'd3, 8'h04, "b2b_rx3");
    pin(K_EQ, 8'd0, "b2b_edges_left");
    tick();
    edge_chk = 1'b0;

    // RX overrun
    for (int b = 0; b < 4; b++) wr(3'd3, 8'(8'h11 + b));
    waitc(80);
    rd(3'd1, 8'h0C, "ovr_rx_full");
    wr(3'd3, 8'h55);
    waitc(25);
    rd(3'd1, 8'h2C, "ovr_set");
    wr(3'd1, 8'h00);
    rd(3'd1, 8'h0C, "ovr_cleared");
    for (int b = 0; b < 4; b++) rd(3'd3, 8'(8'h11 + b), "ovr_rx_kept");
    rd(3'd1, 8'h14, "ovr_drained");

    // Reset mid-byte with two bytes queued
    wr(3'd4, 8'h01);
    wr(3'd3, 8'h96);
    p = cyc_n;
    wr(3'd3, 8'h97);
    wr(3'd3, 8'h98);
    while (cyc_n < p + 15) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    pin(K_SCK, 8'd0, "rstmid_sck");
    pin(K_MOSI, 8'd0, "rstmid_mosi");
    tick();
    rd(3'd1, 8'h14, "rstmid_status");
    waitc(40);
    rd(3'd1, 8'h14, "rstmid_status_late");
    rd(3'd3, 8'h00, "rstmid_no_rx");
    rd(3'd2, 8'h00, "rstmid_ss");
    rd(3'd4, 8'h01, "rstmid_div");

    waitc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
